sqrt_arbiter: RTL and testbench

SQRT_ARBITER -- requirements
Module: sqrt_arbiter

---
 rtl/sqrt_arbiter_pkg.sv | 14 +
 rtl/sqrt_arbiter_if.sv | 29 ++
 rtl/sqrt_iter_core.sv | 60 ++++++
 rtl/sqrt_arbiter.sv | 112 +++++++++++
 tb/tb_sqrt_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sqrt_arbiter_pkg.sv
// Shared types and constants for the round-robin square-root arbiter.
package sqrt_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_DW    = 8;
    localparam int DEF_NREQ  = 4;
    localparam int FRAC_BITS = 4;

endpackage

// File: rtl/sqrt_arbiter_if.sv
// Requester/consumer bus of the square-root arbiter; slave is the arbiter's view.
interface sqrt_arbiter_if
    import sqrt_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW   = DEF_DW
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]    i_req_valid;
    logic [NREQ*DW-1:0] i_req_data;
    logic [NREQ-1:0]    o_req_ready;
    logic               o_rsp_valid;
    logic [IDW-1:0]     o_rsp_id;
    logic [DW-1:0]      o_rsp_data;
    logic               i_rsp_ready;
    logic               o_busy;

    modport slave (
        input  i_req_valid, i_req_data, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_busy
    );

    modport master (
        output i_req_valid, i_req_data, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_busy
    );

endinterface

// File: rtl/sqrt_iter_core.sv
// Restoring digit-by-digit square root, one result bit per cycle, of {operand, DW'b0}.
// Build option SQRT_ARBITER_ROUNDING_EN rounds the result to nearest instead of truncating.
module sqrt_iter_core
    import sqrt_arbiter_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [DW-1:0] i_operand,
    output logic [DW-1:0] o_result,
    output logic          o_last
);
    localparam int CW = $clog2(DW + 1);

    logic [2*DW-1:0] rad_q;
    logic [DW+1:0]   rem_q;
    logic [DW-1:0]   root_q;
    logic [CW-1:0]   cnt_q;

    logic [DW+1:0]   shifted;
    logic [DW+1:0]   trial;
    logic [DW+1:0]   diff;
    logic            fits;

    // Remainder never exceeds 2*root, so the bits shifted out of the top are always zero.
    assign shifted = (rem_q << 2) | {{DW{1'b0}}, rad_q[2*DW-1 -: 2]};
    assign trial   = {root_q, 2'b01};
    assign fits    = (shifted >= trial);
    assign diff    = shifted - trial;
    assign o_last  = (cnt_q == CW'(1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
        end else if (i_start) begin
            rad_q  <= {i_operand, {DW{1'b0}}};
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= CW'(DW);
        end else if (cnt_q != '0) begin
            rad_q  <= rad_q << 2;
            rem_q  <= fits ? diff : shifted;
            root_q <= {root_q[DW-2:0], fits};
            cnt_q  <= cnt_q - 1'b1;
        end
    end

`ifdef SQRT_ARBITER_ROUNDING_EN
    // remainder > root means sqrt lies at or above root + 0.5
    assign o_result = ((rem_q > {2'b00, root_q}) && (root_q != '1)) ? root_q + 1'b1 : root_q;
`else
    assign o_result = root_q;
`endif

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one iterative UQ8.0 -> UQ4.4 square-root datapath among NREQ requesters.
// Rounding behaviour of the datapath is selected by SQRT_ARBITER_ROUNDING_EN.
//
// state   | meaning
// IDLE    | offer ready to the round-robin winner, accept one operand
// CALC    | datapath iterating, one result bit per cycle
// DONE    | result presented until the consumer takes it
module sqrt_arbiter
    import sqrt_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW   = DEF_DW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    sqrt_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    state_t          state_q;
    state_t          state_d;
    logic [IDW-1:0]  last_grant_q;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic [NREQ-1:0] grant_vec;
    logic            accept;
    logic [DW-1:0]   operand;
    logic [DW-1:0]   result;
    logic            core_last;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin : arbitrate
        int             k;
        logic [IDW-1:0] kk;
        grant_any = 1'b0;
        grant_idx = '0;
        k         = 0;
        kk        = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(last_grant_q) + 1 + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            kk = k[IDW-1:0];
            if (!grant_any && bus.i_req_valid[kk]) begin
                grant_any = 1'b1;
                grant_idx = kk;
            end
        end
    end

    always_comb begin
        operand = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                operand = bus.i_req_data[i*DW +: DW];
            end
        end
    end

    assign accept = (state_q == ST_IDLE) && grant_any;

    always_comb begin
        grant_vec = '0;
        if ((state_q == ST_IDLE) && !i_reset && grant_any) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= grant_idx;
                id_q         <= grant_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_any)       state_d = ST_CALC;
            ST_CALC: if (core_last)       state_d = ST_DONE;
            ST_DONE: if (bus.i_rsp_ready) state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    sqrt_iter_core #(
        .DW (DW)
    ) u_core (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (accept),
        .i_operand (operand),
        .o_result  (result),
        .o_last    (core_last)
    );

    assign bus.o_req_ready = grant_vec;
    assign bus.o_rsp_valid = (state_q == ST_DONE);
    assign bus.o_rsp_id    = (state_q == ST_DONE) ? id_q : '0;
    assign bus.o_rsp_data  = (state_q == ST_DONE) ? result : '0;
    assign bus.o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Self-checking bench for sqrt_arbiter: scoreboard of reference roots, directed and sweep stimulus.
module tb_sqrt_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic i_clk = 1'b0;
    logic i_reset;

    always #5 i_clk = ~i_clk;

    sqrt_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    sqrt_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    typedef struct {
        int id;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   acc_cyc   = 0;
    int   n_rsp     = 0;
    int   n_rise    = 0;
    int   last_data = 0;
    int   last_id   = 0;

    task automatic check_eq(string tag, int obs, int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_sqrt(int x);
        int n;
        int r;
        n = x * 256;
        r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
`ifdef SQRT_ARBITER_ROUNDING_EN
        if ((n - r * r > r) && (r < 255)) r++;
`endif
        return r;
    endfunction

    function automatic int idx_of(logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    // Monitor: push expectations on accepted requests, pop and compare on taken responses.
    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                exp_q.delete();
                prev_valid = 1'b0;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    if (bus.i_req_valid[k] && bus.o_req_ready[k]) begin
                        exp_q.push_back('{id: k, data: ref_sqrt(int'(bus.i_req_data[k*DW +: DW]))});
                        acc_cyc = cyc;
                    end
                end
                if (bus.o_rsp_valid && !prev_valid) begin
                    n_rise++;
                    check_eq("latency", cyc - acc_cyc - 1, DW);
                end
                if (bus.o_rsp_valid && bus.i_rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("sb_nonempty", exp_q.size(), 1);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check_eq("sb_id", int'(bus.o_rsp_id), e.id);
                        check_eq("sb_data", int'(bus.o_rsp_data), e.data);
                        last_data = int'(bus.o_rsp_data);
                        last_id   = int'(bus.o_rsp_id);
                        n_rsp++;
                    end
                end
                prev_valid = bus.o_rsp_valid;
            end
        end
    end

    task automatic send(int k, logic [7:0] x);
        int t;
        t = 0;
        bus.i_req_valid[k]        = 1'b1;
        bus.i_req_data[k*DW +: DW] = x;
        do begin
            @(negedge i_clk);
            t++;
        end while (!bus.o_req_ready[k] && t < 100);
        check_eq("send_tmo", int'(t >= 100), 0);
        @(posedge i_clk);
        #1;
        bus.i_req_valid[k] = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((bus.o_busy || exp_q.size() != 0) && t < 200) begin
            @(negedge i_clk);
            t++;
        end
        check_eq("idle_tmo", int'(t >= 200), 0);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gcyc[5];
        int t;
        int rise0;
        logic [7:0] dops[3];
        logic [7:0] dexp[3];

        i_reset         = 1'b1;
        bus.i_rsp_ready = 1'b1;
        bus.i_req_valid = '1;
        bus.i_req_data  = {8'h40, 8'h19, 8'h09, 8'h04};
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check_eq("rst_ready", int'(bus.o_req_ready), 0);
        check_eq("rst_valid", int'(bus.o_rsp_valid), 0);
        check_eq("rst_id",    int'(bus.o_rsp_id), 0);
        check_eq("rst_data",  int'(bus.o_rsp_data), 0);
        check_eq("rst_busy",  int'(bus.o_busy), 0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        // Round robin with all requesters continuously valid.
        for (int g = 0; g < 5; g++) begin
            t = 0;
            do begin
                @(negedge i_clk);
                t++;
            end while (bus.o_req_ready == '0 && t < 50);
            check_eq("rr_tmo", int'(t >= 50), 0);
            check_eq("rr_onehot", $countones(bus.o_req_ready), 1);
            check_eq("rr_grant", idx_of(bus.o_req_ready), g % NREQ);
            gcyc[g] = cyc;
            if (g > 0) check_eq("rr_gap", gcyc[g] - gcyc[g-1], DW + 2);
            @(posedge i_clk);
            #1;
            if (g == 4) bus.i_req_valid = '0;
        end
        wait_idle();

        send(0, 8'h10);
        wait_idle();
        check_eq("d10_data", last_data, 8'h40);
        check_eq("d10_id",   last_id, 0);

        dops[0] = 8'h02;
`ifdef SQRT_ARBITER_ROUNDING_EN
        dexp[0] = 8'h17;
`else
        dexp[0] = 8'h16;
`endif
        dops[1] = 8'hFF; dexp[1] = 8'hFF;
        dops[2] = 8'h00; dexp[2] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            send(0, dops[i]);
            wait_idle();
            check_eq("dir_data", last_data, int'(dexp[i]));
        end

        // Consumer backpressure in DONE with another request pending.
        bus.i_rsp_ready = 1'b0;
        send(1, 8'h40);
        bus.i_req_valid[2]    = 1'b1;
        bus.i_req_data[23:16] = 8'h31;
        t = 0;
        do begin
            @(negedge i_clk);
            t++;
        end while (!bus.o_rsp_valid && t < 50);
        check_eq("bp_tmo", int'(t >= 50), 0);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", int'(bus.o_rsp_valid), 1);
            check_eq("bp_data",  int'(bus.o_rsp_data), 8'h80);
            check_eq("bp_id",    int'(bus.o_rsp_id), 1);
            check_eq("bp_ready", int'(bus.o_req_ready), 0);
            @(negedge i_clk);
        end
        @(posedge i_clk);
        #1;
        bus.i_rsp_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        check_eq("bp_idle_busy", int'(bus.o_busy), 0);
        check_eq("bp_idle_grant", int'(bus.o_req_ready), 4'b0100);
        @(posedge i_clk);
        #1;
        bus.i_req_valid[2] = 1'b0;
        wait_idle();
        check_eq("bp_next_data", last_data, 8'h70);
        check_eq("bp_next_id",   last_id, 2);

        // Reset three cycles into CALC aborts the job.
        send(2, 8'h99);
        repeat (2) @(posedge i_clk);
        #1;
        rise0   = n_rise;
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        check_eq("abort_busy", int'(bus.o_busy), 0);
        repeat (12) @(negedge i_clk);
        check_eq("abort_norsp", n_rise - rise0, 0);
        @(posedge i_clk);
        #1;
        bus.i_req_valid = '1;
        @(negedge i_clk);
        check_eq("abort_grant", int'(bus.o_req_ready), 4'b0001);
        @(posedge i_clk);
        #1;
        bus.i_req_valid = '0;
        wait_idle();

        for (int x = 0; x < 256; x++) begin
            send(x % NREQ, 8'(x));
        end
        wait_idle();
        check_eq("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
